mem_interface: RTL and testbench
================================

MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles waiting for bus_ack before error (range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 MemRead  in  1  controller read strobe, held for the whole access.
REQ-005 MemWrite  in  1  controller write strobe, held for the whole access.
REQ-006 IRWrite  in  1  read result also loads instruction register.
REQ-007 IorD  in  1  address select: 0 = pc, 1 = alu_out.
REQ-008 pc  in  32  program counter.
REQ-009 alu_out  in  32  ALUOut register (data address).
REQ-010 wdata  in  32  store data (B register).
REQ-011 bus_req  out  1  registered memory request.
REQ-012 bus_we  out  1  registered write enable, valid with bus_req.
REQ-013 bus_addr  out  32  registered word address, valid with bus_req.
REQ-014 bus_wdata  out  32  registered store data, valid with bus_req.
REQ-015 bus_rdata  in  32  read data, sampled only with bus_ack.
REQ-016 bus_ack  in  1  single-cycle completion pulse from memory.
REQ-017 instr  out  32  instruction register.
REQ-018 opcode  out  6  instr[31:26], combinational.
REQ-019 func  out  6  instr[5:0], combinational.
REQ-020 mdr  out  32  memory data register.
REQ-021 stall  out  1  combinational; controller holds its state while high.
REQ-022 mem_err  out  1  sticky error flag.

Function
REQ-023 States: IDLE, BUSY, DONE, ERR.
REQ-024 IDLE, cmd = MemRead^MemWrite, address A = IorD ? alu_out : pc: if A[1:0]==0 -> latch bus_addr=A, bus_we=MemWrite, bus_wdata=wdata, IRWrite as ir_sel; set bus_req=1; clear timeout counter; go BUSY.
REQ-025 IDLE, MemRead&MemWrite both high, or cmd with A[1:0]!=0 -> go ERR; no bus request issued.
REQ-026 IDLE, neither strobe -> stay IDLE; bus_req=0.
REQ-027 BUSY, bus_ack=1 -> bus_req<=0; if read: mdr<=bus_rdata, and instr<=bus_rdata when ir_sel; go DONE.
REQ-028 BUSY, no ack -> counter increments; when counter reaches TIMEOUT-1 without ack -> bus_req<=0, go ERR.
REQ-029 DONE -> IDLE unconditionally; strobes present in DONE are ignored (no new access).
REQ-030 ERR -> stays ERR until rst; mem_err=1 in ERR; bus_req=0.
REQ-031 stall = (IDLE & any strobe) | BUSY | ERR; stall=0 in DONE.
REQ-032 Minimum access: accept cycle (IDLE), BUSY with ack in same cycle, DONE -> 3 cycles, stall high for 2.
REQ-033 Writes leave instr and mdr unchanged.
REQ-034 bus_ack outside BUSY ignored; instr/mdr unchanged.
REQ-035 bus_addr/bus_we/bus_wdata stable for the entire BUSY interval regardless of input changes.
REQ-036 instr and mdr hold value between accesses.

Reset
REQ-037 rst=1 at posedge: state IDLE; bus_req, bus_we, mem_err, instr, mdr, bus_addr, bus_wdata, counter all 0.
REQ-038 rst mid-BUSY: bus_req=0 after that edge; subsequent late bus_ack ignored.
REQ-039 rst has priority over every transition including ERR exit.

Verification
REQ-040 Fetch: pc=0x40, MemRead=1, IRWrite=1, IorD=0, ack 1 cycle after bus_req with rdata=0x8C220004 -> bus_addr=0x40, bus_we=0; instr=mdr=0x8C220004, opcode=0x23, func=0x04; stall high exactly 2 cycles.
REQ-041 Store: IorD=1, alu_out=0x100, wdata=0xDEADBEEF, MemWrite=1, ack after 3 wait cycles -> bus_we=1, bus_wdata=0xDEADBEEF held 4 cycles; mdr, instr unchanged; stall high 5 cycles.
REQ-042 Misaligned: IorD=1, alu_out=0x102, MemRead=1 -> bus_req never asserts; mem_err=1 and stall=1 from next cycle until rst.
REQ-043 Timeout: TIMEOUT=16, MemRead=1, no ack -> bus_req high 16 cycles then 0; mem_err=1; ack arriving afterwards has no effect.
REQ-044 Reset mid-access: rst during BUSY, then ack with rdata=0x12345678 -> bus_req=0, instr=mdr=0, state IDLE.
REQ-045 Back-to-back: strobe held through DONE -> no second bus_req in DONE; new access starts only in the following IDLE cycle.

Source files
------------

// File: rtl/mem_interface.sv
// Memory bus adapter for a multicycle CPU: turns controller read/write strobes into one
// registered bus request. It captures read data into MDR/IR, stalls the controller, and
// traps misaligned accesses, conflicting strobes and bus timeouts in a sticky error state.
module mem_interface #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        irsel_q, irsel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] addr_sel;
    logic        any_strobe;
    logic        cmd;

    always_comb begin
        addr_sel   = IorD ? alu_out : pc;
        any_strobe = MemRead | MemWrite;
        cmd        = MemRead ^ MemWrite;
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        irsel_d    = irsel_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        instr_d    = instr_q;
        mdr_d      = mdr_q;
        case (state_q)
            IDLE: begin
                if (cmd && (addr_sel[1:0] == 2'b00)) begin
                    addr_d  = addr_sel;
                    we_d    = MemWrite;
                    wd_d    = wdata;
                    irsel_d = IRWrite;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end else if (any_strobe) begin
                    // both strobes at once, or a single strobe with an unaligned address
                    state_d = ERR;
                end
            end
            BUSY: begin
                // an ack in the last allowed cycle still completes the access
                if (bus_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        mdr_d = bus_rdata;
                        if (irsel_q) instr_d = bus_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                req_d   = 1'b0;
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            irsel_q <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            instr_q <= 32'd0;
            mdr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            irsel_q <= irsel_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wd_q;
    assign instr     = instr_q;
    assign mdr       = mdr_q;
    assign opcode    = instr_q[31:26];
    assign func      = instr_q[5:0];
    assign stall     = ((state_q == IDLE) && any_strobe) || (state_q == BUSY) || (state_q == ERR);
    assign mem_err   = (state_q == ERR);

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: random and directed accesses are checked against
// a transaction-level model of the expected bus, stall, MDR and IR behaviour.
module tb_mem_interface;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, IRWrite, IorD;
    logic [31:0] pc, alu_out, wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] instr;
    logic [5:0]  opcode, func;
    logic [31:0] mdr;
    logic        stall, mem_err;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instr = 32'd0;
    logic [31:0] exp_mdr = 32'd0;

    mem_interface #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .IorD(IorD), .pc(pc), .alu_out(alu_out), .wdata(wdata), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .instr(instr), .opcode(opcode), .func(func), .mdr(mdr),
        .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MemRead = 0; MemWrite = 0; IRWrite = 0; IorD = 0;
        pc = 0; alu_out = 0; wdata = 0; bus_rdata = 0; bus_ack = 0;
    endtask

    // One aligned access; ack arrives after wait_n wait cycles. With hold=1 the strobes
    // stay asserted through DONE so that the next call forms a back-to-back access.
    task automatic run_access(input logic rd, input logic wr, input logic ir, input logic iord,
                              input logic [31:0] pc_v, input logic [31:0] alu_v,
                              input logic [31:0] wd_v, input logic [31:0] rd_v,
                              input int wait_n, input logic hold, input string name);
        logic [31:0] exp_addr;
        exp_addr = iord ? alu_v : pc_v;
        MemRead = rd; MemWrite = wr; IRWrite = ir; IorD = iord;
        pc = pc_v; alu_out = alu_v; wdata = wd_v; bus_ack = 0;
        @(negedge clk);
        checks++;
        if ({stall, bus_req} !== 2'b10) begin
            failures++;
            $display("FAIL %s accept: stall,bus_req=%b expected 10", name, {stall, bus_req});
        end
        next_cycle();
        for (int k = 0; k <= wait_n; k++) begin
            bus_ack = (k == wait_n);
            bus_rdata = (k == wait_n) ? rd_v : $urandom;
            pc = $urandom; alu_out = $urandom; wdata = $urandom;
            IRWrite = 1'($urandom); IorD = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({bus_req, bus_we, stall} !== {1'b1, wr, 1'b1}) begin
                failures++;
                $display("FAIL %s busy%0d ctrl: req,we,stall=%b expected %b", name, k,
                         {bus_req, bus_we, stall}, {1'b1, wr, 1'b1});
            end
            checks++;
            if (bus_addr !== exp_addr) begin
                failures++;
                $display("FAIL %s busy%0d addr: got %h expected %h", name, k, bus_addr, exp_addr);
            end
            checks++;
            if (bus_wdata !== wd_v) begin
                failures++;
                $display("FAIL %s busy%0d wdata: got %h expected %h", name, k, bus_wdata, wd_v);
            end
            next_cycle();
        end
        bus_ack = 0;
        if (!hold) begin
            MemRead = 0; MemWrite = 0;
        end
        if (rd) begin
            exp_mdr = rd_v;
            if (ir) exp_instr = rd_v;
        end
        @(negedge clk);
        checks++;
        if ({bus_req, stall, mem_err} !== 3'b000) begin
            failures++;
            $display("FAIL %s done ctrl: req,stall,err=%b expected 000", name, {bus_req, stall, mem_err});
        end
        checks++;
        if (mdr !== exp_mdr || instr !== exp_instr) begin
            failures++;
            $display("FAIL %s regs: mdr=%h instr=%h expected mdr=%h instr=%h", name, mdr, instr,
                     exp_mdr, exp_instr);
        end
        checks++;
        if (opcode !== exp_instr[31:26] || func !== exp_instr[5:0]) begin
            failures++;
            $display("FAIL %s decode: opcode=%h func=%h expected %h %h", name, opcode, func,
                     exp_instr[31:26], exp_instr[5:0]);
        end
        next_cycle();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
        exp_instr = 0; exp_mdr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, mem_err, stall} !== 4'b0000) begin
            failures++;
            $display("FAIL reset ctrl: req,we,err,stall=%b expected 0000", {bus_req, bus_we, mem_err, stall});
        end
        checks++;
        if ({instr, mdr, bus_addr, bus_wdata} !== 128'd0) begin
            failures++;
            $display("FAIL reset data: instr=%h mdr=%h addr=%h wdata=%h expected all 0",
                     instr, mdr, bus_addr, bus_wdata);
        end
        rst = 0;
        next_cycle();
    endtask

    task automatic test_fetch();
        run_access(1, 0, 1, 0, 32'h40, $urandom, $urandom, 32'h8C220004, 0, 0, "fetch");
        checks++;
        if (opcode !== 6'h23 || func !== 6'h04 || instr !== 32'h8C220004) begin
            failures++;
            $display("FAIL fetch fields: opcode=%h func=%h instr=%h expected 23 04 8c220004",
                     opcode, func, instr);
        end
    endtask

    task automatic test_store();
        run_access(0, 1, 0, 1, $urandom, 32'h100, 32'hDEADBEEF, $urandom, 3, 0, "store");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic rd;
            logic [31:0] pv, av;
            rd = 1'($urandom);
            pv = $urandom; pv[1:0] = 2'b00;
            av = $urandom; av[1:0] = 2'b00;
            run_access(rd, !rd, 1'($urandom), 1'($urandom), pv, av, $urandom, $urandom,
                       $urandom_range(0, TO - 2), 0, "random");
            bus_ack = 1; bus_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({bus_req, stall} !== 2'b00) begin
                failures++;
                $display("FAIL stray_ack ctrl: req,stall=%b expected 00", {bus_req, stall});
            end
            next_cycle();
            bus_ack = 0;
            @(negedge clk);
            checks++;
            if (mdr !== exp_mdr || instr !== exp_instr) begin
                failures++;
                $display("FAIL stray_ack regs: mdr=%h instr=%h expected %h %h", mdr, instr,
                         exp_mdr, exp_instr);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        run_access(1, 0, 1, 0, 32'h200, 32'h0, 32'h0, 32'hA5A50001, 1, 1, "b2b_first");
        run_access(1, 0, 1, 0, 32'h200, 32'h0, 32'h0, 32'h5A5A0002, 0, 0, "b2b_second");
    endtask

    task automatic test_ack_at_limit();
        run_access(1, 0, 0, 1, 32'h0, 32'h3F0, 32'h0, 32'hCAFEF00D, TO - 1, 0, "ack_limit");
    endtask

    task automatic test_timeout();
        run_access(1, 0, 1, 0, 32'h80, 32'h0, 32'h0, 32'h11223344, 0, 0, "pre_timeout");
        MemRead = 1; pc = 32'h84;
        next_cycle();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_req, mem_err} !== 2'b10) begin
                failures++;
                $display("FAIL timeout busy%0d: req,err=%b expected 10", i, {bus_req, mem_err});
            end
            next_cycle();
        end
        bus_ack = 1; bus_rdata = 32'h99999999;
        @(negedge clk);
        checks++;
        if ({bus_req, mem_err, stall} !== 3'b011) begin
            failures++;
            $display("FAIL timeout err: req,err,stall=%b expected 011", {bus_req, mem_err, stall});
        end
        next_cycle();
        bus_ack = 0; MemRead = 0;
        @(negedge clk);
        checks++;
        if (mdr !== exp_mdr || instr !== exp_instr || mem_err !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL timeout late_ack: mdr=%h instr=%h err=%b stall=%b expected %h %h 1 1",
                     mdr, instr, mem_err, stall, exp_mdr, exp_instr);
        end
        next_cycle();
        do_reset();
    endtask

    task automatic err_scenario(input logic rd, input logic wr, input logic [31:0] addr,
                                input string name);
        run_access(1, 0, 1, 0, 32'h10, 32'h0, 32'h0, $urandom, 0, 0, "pre_err");
        MemRead = rd; MemWrite = wr; IorD = 1; alu_out = addr;
        @(negedge clk);
        checks++;
        if ({stall, bus_req} !== 2'b10) begin
            failures++;
            $display("FAIL %s accept: stall,req=%b expected 10", name, {stall, bus_req});
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            bus_ack = 1'($urandom); bus_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({mem_err, stall, bus_req} !== 3'b110 || mdr !== exp_mdr) begin
                failures++;
                $display("FAIL %s hold%0d: err,stall,req=%b mdr=%h expected 110 %h", name, i,
                         {mem_err, stall, bus_req}, mdr, exp_mdr);
            end
            next_cycle();
        end
        bus_ack = 0;
        rst = 1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_err, bus_req} !== 2'b00 || mdr !== 32'd0 || instr !== 32'd0) begin
            failures++;
            $display("FAIL %s reset_exit: err,req=%b mdr=%h instr=%h expected 00 0 0", name,
                     {mem_err, bus_req}, mdr, instr);
        end
        clear_inputs();
        rst = 0;
        exp_instr = 0; exp_mdr = 0;
        next_cycle();
    endtask

    task automatic test_errors();
        err_scenario(1, 0, 32'h102, "misaligned_rd");
        err_scenario(0, 1, 32'h201, "misaligned_wr");
        err_scenario(1, 1, 32'h100, "both_strobes");
    endtask

    task automatic test_reset_mid();
        run_access(1, 0, 1, 0, 32'h20, 32'h0, 32'h0, 32'h0BADF00D, 0, 0, "pre_rstmid");
        MemRead = 1; IRWrite = 1; IorD = 0; pc = 32'h24;
        next_cycle();
        next_cycle();
        rst = 1;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid busy: req=%b expected 1", bus_req);
        end
        next_cycle();
        rst = 0; MemRead = 0; IRWrite = 0;
        bus_ack = 1; bus_rdata = 32'h12345678;
        exp_instr = 0; exp_mdr = 0;
        @(negedge clk);
        checks++;
        if ({bus_req, stall, mem_err} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid after: req,stall,err=%b expected 000", {bus_req, stall, mem_err});
        end
        next_cycle();
        bus_ack = 0;
        @(negedge clk);
        checks++;
        if (instr !== exp_instr || mdr !== exp_mdr || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid late_ack: instr=%h mdr=%h req=%b expected 0 0 0", instr, mdr, bus_req);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_random();
        test_back_to_back();
        test_ack_at_limit();
        test_timeout();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
